// File: rtl/dm_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// one req/gnt handshake per access, then a single rvalid response with optional err.
interface dm_lsu_if #(
  parameter int XLEN = 32
);
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/dm_lsu.sv
// MEM-stage load/store unit: formats sub-word stores, aligns/extends loads; MISALIGN_TRAP_EN faults misaligned half/word.
// Latency >= 3 stall cycles + DONE; stalls the pipeline while waiting on bus_gnt and bus_rvalid.
module dm_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m_mem_read,
  input  logic            m_mem_write,
  input  logic [2:0]      m_funct3,
  input  logic [XLEN-1:0] m_alu_y,
  input  logic [XLEN-1:0] m_rrd2,
  output logic            lsu_stall,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_fault,
  dm_lsu_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_fault;

  logic            w_access;
  logic            w_mis;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  // Read+write together is treated as a store.
  assign w_access = m_mem_read | m_mem_write;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = m_rrd2;
    case (m_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << m_alu_y[1:0];
        w_wdata = {4{m_rrd2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {m_alu_y[1], 1'b0};
        w_wdata = {2{m_rrd2[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_mis = ((m_funct3[1:0] == 2'b01) & m_alu_y[0]) |
                 ((m_funct3 == 3'b010) & (m_alu_y[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Lane selection uses the captured address; half ignores a[0], word ignores a[1:0].
  assign w_byte = bus.bus_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = bus.bus_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = bus.bus_rdata;
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus.bus_rdata;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    lsu_stall = 1'b0;
    case (r_state)
      IDLE: begin
        lsu_stall = w_access;
        if (w_access) w_next = w_mis ? DONE : REQ;
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (bus.bus_gnt) w_next = RESP;
      end
      RESP: begin
        lsu_stall = 1'b1;
        if (bus.bus_rvalid) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_be    <= 4'd0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_access) begin
        r_we    <= m_mem_write;
        r_f3    <= m_funct3;
        r_addr  <= m_alu_y;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_rdata <= '0;
        r_fault <= w_mis;
      end
      if ((r_state == RESP) && bus.bus_rvalid) begin
        r_fault <= bus.bus_err;
        r_rdata <= (bus.bus_err | r_we) ? '0 : w_load;
      end
    end
  end

  assign bus.bus_req   = (r_state == REQ);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_addr[XLEN-1:2], 2'b00};
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;
  assign lsu_rdata     = r_rdata;
  assign lsu_fault     = r_fault;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: lockstep responder with randomized gnt/rvalid delays against an arithmetic reference model.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_mem_read;
  logic        m_mem_write;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_y;
  logic [31:0] m_rrd2;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_fault;

  int n_cmp = 0;
  int n_bad = 0;

  dm_lsu_if #(.XLEN(32)) bus();

  dm_lsu #(.XLEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_mem_read  (m_mem_read),
    .m_mem_write (m_mem_write),
    .m_funct3    (m_funct3),
    .m_alu_y     (m_alu_y),
    .m_rrd2      (m_rrd2),
    .lsu_stall   (lsu_stall),
    .lsu_rdata   (lsu_rdata),
    .lsu_fault   (lsu_fault),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, written from the access rules with plain arithmetic.
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3 % 4)
      0:       return 4'(1 << (a % 4));
      1:       return 4'(3 << (2 * ((a / 2) % 2)));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3 % 4)
      0:       return (d % 256) * 32'h0101_0101;
      1:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * (a % 4))) % 256;
        if (f3 == 3'b000 && v >= 128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * ((a / 2) % 2))) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return ((f3 % 4 == 1) && (a % 2 == 1)) || ((f3 == 3'b010) && (a % 4 != 0));
`else
    return (f3 === 3'bxxx) && (a === 32'hx);
`endif
  endfunction

  // One complete access: IDLE cycle, gw grant-wait cycles, rw response-wait cycles, DONE.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int gw, input int rw, input bit err,
                        input logic [31:0] rdat, input bit spurious);
    bit          we;
    bit          mis;
    logic [31:0] exp_rd;
    bit          exp_fault;
    int          stalls;
    we        = wr;
    mis       = ref_mis(f3, a);
    exp_rd    = (err || we || mis) ? 32'd0 : ref_load(f3, a, rdat);
    exp_fault = err || mis;
    @(negedge clk);
    m_mem_read  = rd;
    m_mem_write = wr;
    m_funct3    = f3;
    m_alu_y     = a;
    m_rrd2      = d;
    #1;
    check("idle_stall", {31'd0, lsu_stall}, 32'd1);
    check("idle_req", {31'd0, bus.bus_req}, 32'd0);
    stalls = int'(lsu_stall);
    if (!mis) begin
      for (int g = 0; g <= gw; g++) begin
        @(negedge clk);
        check("req", {31'd0, bus.bus_req}, 32'd1);
        check("addr", bus.bus_addr, a & 32'hFFFF_FFFC);
        check("be", {28'd0, bus.bus_be}, {28'd0, ref_be(f3, a)});
        check("we", {31'd0, bus.bus_we}, {31'd0, we});
        check("wdata", bus.bus_wdata, ref_wdata(f3, d));
        stalls += int'(lsu_stall);
        bus.bus_gnt    = (g == gw);
        bus.bus_rvalid = spurious && (g != gw);
        bus.bus_rdata  = $urandom;
        bus.bus_err    = 1'($urandom_range(0, 1));
      end
      for (int r = 0; r <= rw; r++) begin
        @(negedge clk);
        check("resp_req", {31'd0, bus.bus_req}, 32'd0);
        stalls += int'(lsu_stall);
        bus.bus_gnt    = 1'b0;
        bus.bus_rvalid = (r == rw);
        bus.bus_rdata  = (r == rw) ? rdat : $urandom;
        bus.bus_err    = (r == rw) ? err : 1'b0;
      end
    end
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    bus.bus_err    = 1'b0;
    check("done_stall", {31'd0, lsu_stall}, 32'd0);
    check("done_req", {31'd0, bus.bus_req}, 32'd0);
    check("done_rdata", lsu_rdata, exp_rd);
    check("done_fault", {31'd0, lsu_fault}, {31'd0, exp_fault});
    check("stall_cycles", stalls, mis ? 32'd1 : 32'(3 + gw + rw));
    m_mem_read  = 1'b0;
    m_mem_write = 1'b0;
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    m_mem_read  = 1'b1;
    m_mem_write = 1'b0;
    m_funct3    = 3'b010;
    m_alu_y     = 32'h0000_3008;
    m_rrd2      = 32'h5555_AAAA;
    @(negedge clk);
    check("rst_pre_req", {31'd0, bus.bus_req}, 32'd1);
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    check("rst_in_resp_stall", {31'd0, lsu_stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, bus.bus_req}, 32'd0);
    check("rst_mid_addr", bus.bus_addr, 32'd0);
    check("rst_mid_be", {28'd0, bus.bus_be}, 32'd0);
    check("rst_mid_stall_access", {31'd0, lsu_stall}, 32'd1);
    m_mem_read = 1'b0;
    #1;
    check("rst_mid_stall_idle", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    m_mem_read     = 1'b0;
    m_mem_write    = 1'b0;
    m_funct3       = 3'd0;
    m_alu_y        = 32'd0;
    m_rrd2         = 32'd0;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = 32'd0;
    bus.bus_err    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, bus.bus_req}, 32'd0);
    check("rst_we", {31'd0, bus.bus_we}, 32'd0);
    check("rst_addr", bus.bus_addr, 32'd0);
    check("rst_be", {28'd0, bus.bus_be}, 32'd0);
    check("rst_wdata", bus.bus_wdata, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_fault", {31'd0, lsu_fault}, 32'd0);
    check("rst_stall", {31'd0, lsu_stall}, 32'd0);
    reset_n = 1'b1;

    access(1, 0, 3'b010, 32'h0000_1004, 32'd0,         0, 0, 0, 32'hDEAD_BEEF, 0);
    access(1, 0, 3'b000, 32'h0000_1003, 32'd0,         0, 0, 0, 32'h80FF_0000, 0);
    access(1, 0, 3'b100, 32'h0000_1003, 32'd0,         1, 0, 0, 32'h80FF_0000, 0);
    access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 2, 0, 0, 32'hFFFF_FFFF, 1);
    access(0, 1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 0, 2, 0, 32'd0,         0);
    access(1, 0, 3'b001, 32'h0000_2002, 32'd0,         0, 1, 0, 32'h9ABC_1234, 0);
    access(1, 0, 3'b101, 32'h0000_2000, 32'd0,         0, 0, 0, 32'h9ABC_F234, 0);
    access(1, 0, 3'b010, 32'h0000_1008, 32'd0,         0, 0, 1, 32'h1111_2222, 0);
    access(1, 0, 3'b010, 32'h0000_100C, 32'd0,         0, 0, 0, 32'h3333_4444, 0);
    access(1, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 1, 1, 0, 32'h7777_7777, 0);
    access(1, 0, 3'b010, 32'h0000_1002, 32'd0,         0, 0, 0, 32'h0BAD_F00D, 0);
    access(1, 0, 3'b001, 32'h0000_1001, 32'd0,         0, 0, 0, 32'h8765_4321, 0);
    access(1, 0, 3'b111, 32'h0000_1006, 32'd0,         0, 0, 0, 32'h0102_0304, 0);

    reset_mid_access();
    access(1, 0, 3'b010, 32'h0000_3008, 32'd0, 0, 0, 0, 32'h0123_4567, 0);

    for (int i = 0; i < 300; i++) begin
      int          op;
      logic [2:0]  f3;
      logic [31:0] a;
      op = $urandom_range(1, 3);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      access(op[0], op[1], f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
